// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment controller.
package display_pkg;

   localparam int DATO_W  = 10;
   localparam int BCD_W   = 16;
   localparam int SHIFT_W = 26;
   localparam int N_ITER  = 10;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      LOAD
   } estado_t;

   // Active-low patterns, bit0 = a ... bit6 = g
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/decodificador_bcd_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes go dark.
module decodificador_bcd_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/controlador_display_4_digitos.sv
// Binary-to-BCD (double dabble, one shift per clock) feeding a 4-digit multiplexed
// active-low 7-segment display with leading-zero blanking.
//
// state | meaning
// IDLE  | waiting for dato_valido; display shows last result
// CONV  | one add-3/shift iteration per clock, 10 total
// LOAD  | copy BCD result to display registers, pulse listo
module controlador_display_4_digitos
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATO_W-1:0] dato,
   input  logic              dato_valido,
   output logic              ocupado,
   output logic              listo,
   output logic [3:0]        anodos,
   output logic [6:0]        segmentos
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   estado_t              estado, estado_n;
   logic                 carga;
   logic [SHIFT_W-1:0]   sr, sr_adj;
   logic [3:0]           iter;
   logic [3:0]           unidades, decenas, centenas, millares;

   logic [CNT_W-1:0]     cnt;
   logic                 wrap;
   logic [1:0]           idx;
   logic                 upd;
   logic [3:0]           digito;
   logic                 blanco;
   logic [6:0]           seg_dec;
   logic [3:0]           anodos_n;
   logic [6:0]           segmentos_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) estado <= IDLE;
      else       estado <= estado_n;
   end

   always_comb begin
      estado_n = estado;
      carga    = 1'b0;
      case (estado)
         IDLE: if (dato_valido) begin
            carga    = 1'b1;
            estado_n = CONV;
         end
         CONV: if (iter == 4'(N_ITER - 1)) estado_n = LOAD;
         LOAD: estado_n = IDLE;
         default: estado_n = IDLE;
      endcase
   end

   assign ocupado = (estado != IDLE);

   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < 4; i++) begin
         if (sr[10 + 4*i +: 4] >= 4'd5) sr_adj[10 + 4*i +: 4] = sr[10 + 4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr       <= '0;
         iter     <= '0;
         unidades <= '0;
         decenas  <= '0;
         centenas <= '0;
         millares <= '0;
         listo    <= 1'b0;
      end else begin
         listo <= (estado == LOAD);
         if (carga) begin
            sr   <= {{BCD_W{1'b0}}, dato};
            iter <= '0;
         end else if (estado == CONV) begin
            sr   <= {sr_adj[SHIFT_W-2:0], 1'b0};
            iter <= iter + 4'd1;
         end else if (estado == LOAD) begin
            unidades <= sr[13:10];
            decenas  <= sr[17:14];
            centenas <= sr[21:18];
            millares <= sr[25:22];
         end
      end
   end

   assign wrap = (cnt == CNT_W'(REFRESH_DIV - 1));

   always_comb begin
      digito = unidades;
      blanco = 1'b0;
      case (idx)
         2'd0: begin digito = unidades; blanco = 1'b0; end
         2'd1: begin digito = decenas;  blanco = (decenas == 4'd0) && (centenas == 4'd0) && (millares == 4'd0); end
         2'd2: begin digito = centenas; blanco = (centenas == 4'd0) && (millares == 4'd0); end
         2'd3: begin digito = millares; blanco = (millares == 4'd0); end
         default: begin digito = unidades; blanco = 1'b0; end
      endcase
   end

   decodificador_bcd_7seg u_dec (
      .bcd (digito),
      .seg (seg_dec)
   );

   assign anodos_n    = blanco ? 4'b1111 : ~(4'b0001 << idx);
   assign segmentos_n = blanco ? SEG_OFF : seg_dec;

   // Outputs latch only on the cycle after an index change so a slot never changes mid-way.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         idx       <= '0;
         upd       <= 1'b0;
         anodos    <= 4'b1110;
         segmentos <= SEG_0;
      end else begin
         cnt <= wrap ? '0 : cnt + CNT_W'(1);
         if (wrap) idx <= idx + 2'd1;
         upd <= wrap;
         if (upd) begin
            anodos    <= anodos_n;
            segmentos <= segmentos_n;
         end
      end
   end

endmodule

// File: tb/tb_controlador_display_4_digitos.sv
// Directed bench for controlador_display_4_digitos with a 4-cycle refresh slot.
module tb_controlador_display_4_digitos;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] dato;
   logic       dato_valido;
   logic       ocupado;
   logic       listo;
   logic [3:0] anodos;
   logic [6:0] segmentos;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   controlador_display_4_digitos #(.REFRESH_DIV(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .dato        (dato),
      .dato_valido (dato_valido),
      .ocupado     (ocupado),
      .listo       (listo),
      .anodos      (anodos),
      .segmentos   (segmentos)
   );

   always #5 clk = ~clk;

   // Edges since reset release; slot shown after edge e is ((e-1)/4)%4.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Converts v with a single-cycle strobe and checks the edge-by-edge handshake.
   task automatic aceptar(input logic [9:0] v);
      @(negedge clk);
      dato        = v;
      dato_valido = 1'b1;
      @(negedge clk);
      dato_valido = 1'b0;
      check("ocupado_e0", ocupado, 1);
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         check($sformatf("listo_e%0d", e), listo, 0);
      end
      check("ocupado_e10", ocupado, 1);
      @(negedge clk);
      check("listo_e11", listo, 1);
      check("ocupado_e11", ocupado, 0);
      @(negedge clk);
      check("listo_e12", listo, 0);
   endtask

   task automatic check_disp(input string tag, input int v);
      int   d[4];
      bit   b[4];
      bit   found;
      int   s;
      d[0] = v % 10;
      d[1] = (v / 10) % 10;
      d[2] = (v / 100) % 10;
      d[3] = v / 1000;
      b[3] = (d[3] == 0);
      b[2] = b[3] && (d[2] == 0);
      b[1] = b[2] && (d[1] == 0);
      b[0] = 1'b0;
      repeat (16) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         found = 1'b0;
         for (int w = 0; w < 8 && !found; w++) begin
            if (cyc % 4 == 3) found = 1'b1;
            else @(negedge clk);
         end
         check({tag, "_slot_timeout"}, found, 1);
         s = ((cyc - 1) / 4) % 4;
         if (b[s]) begin
            check($sformatf("%s_an%0d", tag, s), anodos, 4'b1111);
            check($sformatf("%s_seg%0d", tag, s), segmentos, 7'b1111111);
         end else begin
            check($sformatf("%s_an%0d", tag, s), anodos, ~(4'b0001 << s) & 4'hf);
            check($sformatf("%s_seg%0d", tag, s), segmentos, seg_tab[d[s]]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      reset       = 1'b1;
      dato        = '0;
      dato_valido = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_anodos", anodos, 4'b1110);
      check("rst_segmentos", segmentos, 7'b1000000);
      check("rst_ocupado", ocupado, 0);
      check("rst_listo", listo, 0);
      reset = 1'b0;

      aceptar(10'd1023);
      check_disp("d1023", 1023);
      aceptar(10'd0);
      check_disp("d0", 0);
      aceptar(10'd7);
      check_disp("d7", 7);
      aceptar(10'd905);
      check_disp("d905", 905);

      // Strobes during CONV/LOAD are dropped; the one right after LOAD is taken.
      @(negedge clk);
      for (int e = 0; e <= 12; e++) begin
         dato_valido = (e == 0 || e == 3 || e == 11 || e == 12);
         dato        = (e == 0) ? 10'd512 : 10'd99;
         @(negedge clk);
         check($sformatf("busy_listo_e%0d", e), listo, (e == 11));
         check($sformatf("busy_ocupado_e%0d", e), ocupado, (e != 11));
      end
      dato_valido = 1'b0;
      for (int e = 13; e <= 24; e++) begin
         @(negedge clk);
         check($sformatf("b99_listo_e%0d", e), listo, (e == 23));
      end
      check_disp("d99", 99);

      // Reset mid-conversion.
      @(negedge clk);
      dato        = 10'd1000;
      dato_valido = 1'b1;
      @(negedge clk);
      dato_valido = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_ocupado_pre", ocupado, 1);
      reset = 1'b1;
      #1;
      check("abort_ocupado_async", ocupado, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int e = 0; e < 16; e++) begin
         @(negedge clk);
         check($sformatf("abort_listo_%0d", e), listo, 0);
      end
      check("abort_ocupado", ocupado, 0);
      check_disp("abort", 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
